// File: rtl/rename_retire_queue_pkg.sv
// Shared rename definitions: per-entry retire state and the tag-width helper.
// Imported by rename_retire_queue; holds no logic of its own.
// Contents: ent_state_e (FREE/PENDING/DONE), rrq_tag_width().
package rename_retire_queue_pkg;

  // Lifecycle of one in-flight entry: allocated -> written back -> retired.
  typedef enum logic [1:0] {
    ENT_FREE    = 2'd0,
    ENT_PENDING = 2'd1,
    ENT_DONE    = 2'd2
  } ent_state_e;

  // Number of tag bits needed to address 'd' entries.
  function automatic int unsigned rrq_tag_width(input int unsigned d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/rename_retire_queue.sv
// In-order retire queue for renamed physical names: entries are enqueued at
// allocation, marked DONE on writeback, and freed in program order.
// Latency: writeback to FE is 1 cycle; with RETIRE_BYPASS_EN defined a
// writeback hitting a PENDING head raises FE in the same cycle (0 cycles).
// Ports: CLK/RST (sync, active-high); ALLOC_E/ALLOC_NAME in, ALLOC_READY/
// ALLOC_TAG out (enqueue side, ALLOC_E ignored while not ready); WB_E/WB_TAG
// in (writeback); FE/NAME_F out (one free pulse per retire); COUNT/EMPTY out.
module rename_retire_queue
  import rename_retire_queue_pkg::*;
#(
  parameter int name_width = 1,
  parameter int depth      = 4,
  parameter int tag_width  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ALLOC_E,
  input  logic [name_width-1:0] ALLOC_NAME,
  output logic                  ALLOC_READY,
  output logic [tag_width-1:0]  ALLOC_TAG,
  input  logic                  WB_E,
  input  logic [tag_width-1:0]  WB_TAG,
  output logic                  FE,
  output logic [name_width-1:0] NAME_F,
  output logic [tag_width:0]    COUNT,
  output logic                  EMPTY
);

  localparam logic [tag_width:0]   DEPTH_C = (tag_width + 1)'(depth);
  localparam logic [tag_width-1:0] ONE_C   = tag_width'(1);

  // Elaboration-time guard: pointer wrap relies on depth == 2**tag_width.
  if ((depth < 2) || (tag_width != int'(rrq_tag_width(depth))) ||
      ((1 << tag_width) != depth)) begin : g_bad_cfg
    $error("rename_retire_queue: depth must be a power of 2 (>=2) and tag_width == log2(depth)");
  end

  ent_state_e            state_q [depth];
  ent_state_e            state_d [depth];
  logic [name_width-1:0] name_q  [depth];
  logic [tag_width-1:0]  head_q, head_d;
  logic [tag_width-1:0]  tail_q, tail_d;
  logic [tag_width:0]    count_q, count_d;

  logic not_full;
  logic do_alloc;
  logic head_done;
  logic retire;

  // Readiness looks only at the registered count, so a retire in the same
  // cycle never opens a slot in a full queue.
  assign not_full  = (count_q < DEPTH_C);
  assign do_alloc  = ALLOC_E && not_full;
  assign head_done = (state_q[head_q] == ENT_DONE);

`ifdef RETIRE_BYPASS_EN
  // Writeback aimed at a PENDING head retires it immediately.
  assign retire = head_done ||
                  (WB_E && (WB_TAG == head_q) && (state_q[head_q] == ENT_PENDING));
`else
  assign retire = head_done;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (WB_E && (state_q[WB_TAG] == ENT_PENDING)) begin
      state_d[WB_TAG] = ENT_DONE;
    end
    // Applied after the writeback so a bypassed head ends up FREE, not DONE.
    if (retire) begin
      state_d[head_q] = ENT_FREE;
      head_d          = head_q + ONE_C;
    end
    // The tail slot is FREE whenever we may allocate, so it cannot collide
    // with the retire above.
    if (do_alloc) begin
      state_d[tail_q] = ENT_PENDING;
      tail_d          = tail_q + ONE_C;
    end

    case ({do_alloc, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < depth; i++) begin
        state_q[i] <= ENT_FREE;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Name storage needs no reset: a slot is only read once it is DONE.
  always_ff @(posedge CLK) begin
    if (!RST && do_alloc) begin
      name_q[tail_q] <= ALLOC_NAME;
    end
  end

  // Outputs are forced to their idle values while RST is asserted, so they
  // are defined even before the first reset edge.
  assign FE          = !RST && retire;
  assign NAME_F      = FE ? name_q[head_q] : '0;
  assign ALLOC_READY = RST || not_full;
  assign ALLOC_TAG   = RST ? '0 : tail_q;
  assign COUNT       = RST ? '0 : count_q;
  assign EMPTY       = RST || (count_q == '0);

endmodule

// File: doc/rename_retire_queue.md
RENAME_RETIRE_QUEUE -- requirements
Module: rename_retire_queue

Interface
REQ-001 SHALL have parameter name_width, 1, width of a physical register name.
REQ-002 SHALL have parameter depth, 4, number of in-flight entries; a power of 2, at least 2.
REQ-003 SHALL have parameter tag_width, 2, equal to log2(depth).
REQ-004 SHALL have port CLK  in  1  single clock; all state updates on posedge CLK.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ALLOC_E  in  1  enqueue of a newly allocated physical name, in program order.
REQ-007 SHALL have port ALLOC_NAME  in  name_width  physical name being allocated.
REQ-008 SHALL have port ALLOC_READY  out  1  queue can accept an enqueue this cycle.
REQ-009 SHALL have port ALLOC_TAG  out  tag_width  tag of the entry the current enqueue writes (tail pointer).
REQ-010 SHALL have port WB_E  in  1  writeback-complete strobe.
REQ-011 SHALL have port WB_TAG  in  tag_width  tag of the completing entry.
REQ-012 SHALL have port FE  out  1  free-enable to the rename file; one pulse per retired entry.
REQ-013 SHALL have port NAME_F  out  name_width  name being retired; the rename file frees that name's predecessor.
REQ-014 SHALL have port COUNT  out  tag_width+1  number of occupied entries.
REQ-015 SHALL have port EMPTY  out  1  COUNT equals 0.

Function
REQ-016 SHALL keep each entry in exactly one of three states: FREE, PENDING, DONE.
REQ-017 SHALL assert ALLOC_READY combinationally when COUNT < depth; a retire in the same cycle SHALL NOT make a full queue ready.
REQ-018 SHALL, on ALLOC_E && ALLOC_READY, write ALLOC_NAME at the tail, set that entry to PENDING, and advance the tail modulo depth.
REQ-019 SHALL ignore ALLOC_E when ALLOC_READY is low: no state change and no error output.
REQ-020 SHALL, on WB_E, move entry WB_TAG from PENDING to DONE; WB_E to a FREE or DONE entry SHALL be ignored, so a repeated writeback is harmless.
REQ-021 SHALL assert FE combinationally when the head entry is DONE; NAME_F SHALL then equal the head name. NAME_F SHALL be 0 when FE is low.
REQ-022 SHALL, when FE is high, set the head entry to FREE and advance the head modulo depth at the clock edge; at most one retire per cycle.
REQ-023 SHALL retire strictly in enqueue order; a DONE entry behind a PENDING head SHALL wait.
REQ-024 SHALL update COUNT as +1 on enqueue only, -1 on retire only, and unchanged when both occur in the same cycle.
REQ-025 SHALL handle the head and tail pointers wrapping past depth-1 to 0 without losing or duplicating entries.
REQ-026 SHALL give a writeback-to-FE latency of 1 cycle for the head entry: WB_E at cycle t produces FE at cycle t+1.

Reset
REQ-027 SHALL, while RST is high at a clock edge, clear both pointers and COUNT to 0 and set all entries to FREE.
REQ-028 SHALL hold these outputs while RST is high and after it: FE=0, NAME_F=0, ALLOC_READY=1, ALLOC_TAG=0, COUNT=0, EMPTY=1.
REQ-029 SHALL, on reset mid-operation, discard all in-flight entries with no FE pulse for them, and SHALL ignore ALLOC_E and WB_E in the reset cycle.

Configuration
REQ-030 SHALL support the macro RETIRE_BYPASS_EN.
REQ-031 SHALL, when RETIRE_BYPASS_EN is defined, also assert FE in the same cycle as a WB_E whose tag equals a PENDING head, giving 0-cycle latency.
REQ-032 SHALL, when RETIRE_BYPASS_EN is undefined, give exactly the 1-cycle latency of REQ-026, with no combinational path from WB_E/WB_TAG to FE.

Structure
REQ-033 SHALL take the entry-state enumeration (FREE/PENDING/DONE) and the tag-width helper from the shared rename package.
REQ-034 SHALL be a single module with no sub-module; head/tail/count logic and entry storage are local.

Verification
REQ-035 Reset, then enqueue names 5, 6, 7 -> ALLOC_TAG returns 0, 1, 2; COUNT reads 3; FE stays 0.
REQ-036 WB_TAG=1 then WB_TAG=0 -> FE with NAME_F=5, then FE with NAME_F=6 on the next cycle; name 7 is never freed.
REQ-037 Fill depth=4 -> ALLOC_READY=0; an extra ALLOC_E is ignored; a simultaneous enqueue and retire with COUNT=3 keeps COUNT=3.
REQ-038 Perform 10 enqueue/writeback/retire rounds -> pointers wrap and NAME_F order equals enqueue order.
REQ-039 Assert RST with 3 PENDING entries -> FE never pulses; COUNT=0 and EMPTY=1 the next cycle.
REQ-040 WB_E to head at cycle t -> FE at t+1 without RETIRE_BYPASS_EN and at t with it; a duplicate WB_E produces no second FE.
